qea_engine: RTL and testbench
=============================

Name: qea_engine

Overview:
- Quantum-circuit emulation accelerator: holds a state vector of 2^n complex amplitudes in an internal state RAM and a gate program in an internal context RAM.
- On start, executes the program gate by gate (2x2 complex unitaries, optionally controlled), then flags completion.
- Host loads the program and state, and reads results back, through dedicated RAM ports.
- Sits under the host/testbench as the top-level compute block.

Parameters:
- PE_NUM_WIDTH, 2, log2 of PE_NUM.
- PE_NUM, 4, amplitudes per state-RAM word (lanes).
- DATA_WIDTH, 32, width of one real or imaginary component.
- MAX_QBIT_WIDTH, 6, width of qubit-count and qubit-index fields.
- ALU_DATA_WIDTH, DATA_WIDTH, multiplier operand width.
- STATE_DATA_WIDTH, 2*DATA_WIDTH, one complex amplitude as {real, imag}.
- STATE_ADDR_WIDTH, 16, state RAM address width.
- GATE_DATA_WIDTH, 2*DATA_WIDTH, matrix element width.
- GATE_ADDR_WIDTH, 6, reserved; no function in this block.
- GATE_CONTEXT_DATA_WIDTH, 2*DATA_WIDTH, context word width.
- GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width.
- NUM_FRAC_BIT, 30, fixed-point fraction bits. Q2.30: 0x40000000 = 1.0.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- i_start  in  1  one-cycle start pulse.
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count n, range 2..(STATE_ADDR_WIDTH+PE_NUM_WIDTH); sampled when i_start is accepted.
- i_ctx_en, i_ctx_wea  in  1 each  context RAM enable / write enable.
- i_ctx_addr  in  GATE_CONTEXT_ADDR_WIDTH  context write address.
- i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context write data.
- i_state_ena, i_state_wea  in  1 each  state port enable / write enable.
- i_state_addra  in  STATE_ADDR_WIDTH  state word address.
- i_state_dina  in  PE_NUM*STATE_DATA_WIDTH  state write data.
- o_complete  out  1  program finished.
- o_state_dout  out  PE_NUM*STATE_DATA_WIDTH  state read data.

Behaviour:
- Amplitude layout: amplitude index k is stored at address k/PE_NUM. Lane (k mod PE_NUM) = 0 occupies the most-significant 64-bit slice. Each slice is {real[63:32], imag[31:0]}, two's complement Q2.30. Qubit q corresponds to bit q of k.
- State port:
  - ena=1, wea=1: writes i_state_dina (all lanes).
  - ena=1: o_state_dout registers the old word at i_state_addra one cycle later (read-first).
  - ena=0: o_state_dout holds its value. Reset value 0.
- Context port: ena and wea both 1 writes i_ctx_data into ctx[i_ctx_addr].
- While busy, host writes to either RAM are ignored. State reads remain allowed.
- Program format: a header word followed by 4 matrix words u00, u01, u10, u11 (each {re, im}).
  - Header [63:60] opcode: 0 = END, 1 = U, 2 = CU, others = no-op (matrix words still skipped).
  - Header [59:54] target qubit, [53:48] control qubit. Other bits are ignored.
- FSM: IDLE -> FETCH -> APPLY -> FETCH ... -> DONE.
  - IDLE: i_start=1 latches n, sets PC=0, clears o_complete, goes to FETCH. i_start is ignored outside IDLE/DONE.
  - FETCH: one cycle to read the header. END -> DONE. Otherwise 4 further cycles to load the matrix words, PC += 5.
  - APPLY: for each of the 2^(n-1) pairs (a0 = k with target bit 0, a1 = k with target bit set):
    - a0' = u00*a0 + u01*a1; a1' = u10*a0 + u11*a1.
    - 2 cycles per pair: read/compute, then write.
    - For CU, pairs whose control bit is 0 are left unchanged but still take 2 cycles.
  - A target >= n, or a CU with control == target or control >= n, makes the gate a no-op with no APPLY cycles.
  - PC reaching 2^GATE_CONTEXT_ADDR_WIDTH-5 is treated as END.
  - DONE: o_complete=1 and held until the next accepted i_start or reset.
- Arithmetic:
  - Complex MAC uses full 64-bit products and a 66-bit sum.
  - Result = sum arithmetically shifted right by NUM_FRAC_BIT (floor), truncated to 32 bits (wraps, no saturation).
- Reset (asynchronous, including mid-run): FSM to IDLE, o_complete=0, o_state_dout=0, PC=0. RAM contents are undefined after reset.

Optional Feature:
- Macro QEA_CTRL_GATE_EN.
  - Defined: opcode 2 (CU) executes as specified.
  - Undefined: opcode 2 is treated as a no-op (its 4 matrix words are skipped), and the control-bit logic is not synthesized.

Test Plan:
- n=3, state amp0=0x40000000_00000000, program H(q0), END. H = all 0x2D413CCC_00000000 except u11=0xD2BEC334_00000000 -> after o_complete, amp0 and amp1 ≈ 0x2D413CCC_00000000 (±1 LSB), all other amplitudes 0.
- n=3, X on q2 (u01 = u10 = 1.0, u00 = u11 = 0), amp0 = 1.0 -> address 1, MS slice = 0x40000000_00000000, address 0 all zero.
- Program = single END word -> o_complete rises within 3 cycles of i_start; state read back unchanged.
- With QEA_CTRL_GATE_EN: H(q0), then CU-X (control q0, target q1) -> amp0 = amp3 ≈ 0x2D413CCC; without the macro -> amp0 = amp1.
- Assert rst_n=0 mid-APPLY -> o_complete=0 immediately; new i_start after reload completes normally.
- State readback: ena=1, addr=A at cycle t -> o_state_dout = word A at t+1; ena=0 -> output holds.

Source files
------------

// File: rtl/qea_engine.sv
// Quantum-circuit emulation engine: applies a program of 2x2 complex gates to a
// 2^n-amplitude state vector. Define QEA_CTRL_GATE_EN to enable controlled (CU) gates.
module qea_engine #(
  parameter int unsigned PE_NUM_WIDTH            = 2,
  parameter int unsigned PE_NUM                  = 4,
  parameter int unsigned DATA_WIDTH              = 32,
  parameter int unsigned MAX_QBIT_WIDTH          = 6,
  parameter int unsigned ALU_DATA_WIDTH          = DATA_WIDTH,
  parameter int unsigned STATE_DATA_WIDTH        = 2 * DATA_WIDTH,
  parameter int unsigned STATE_ADDR_WIDTH        = 16,
  parameter int unsigned GATE_DATA_WIDTH         = 2 * DATA_WIDTH,
  parameter int unsigned GATE_ADDR_WIDTH         = 6,
  parameter int unsigned GATE_CONTEXT_DATA_WIDTH = 2 * DATA_WIDTH,
  parameter int unsigned GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int unsigned NUM_FRAC_BIT            = 30
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]              i_qbit_num,
  input  logic                                   i_ctx_en,
  input  logic                                   i_ctx_wea,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]     i_ctx_addr,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]     i_ctx_data,
  input  logic                                   i_state_ena,
  input  logic                                   i_state_wea,
  input  logic [STATE_ADDR_WIDTH-1:0]            i_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]     i_state_dina,
  output logic                                   o_complete,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]     o_state_dout
);

  localparam int unsigned AMP_W   = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int unsigned PAIR_W  = AMP_W - 1;
  localparam int unsigned WORD_W  = PE_NUM * STATE_DATA_WIDTH;
  localparam int unsigned SDEPTH  = 1 << STATE_ADDR_WIDTH;
  localparam int unsigned CDEPTH  = 1 << GATE_CONTEXT_ADDR_WIDTH;
  localparam int unsigned CAW     = GATE_CONTEXT_ADDR_WIDTH;
  localparam int unsigned CDW     = GATE_CONTEXT_DATA_WIDTH;
  localparam int unsigned MW      = 2 * ALU_DATA_WIDTH + 2;
  localparam logic [CAW-1:0] PC_LIMIT = CAW'(CDEPTH - 5);
  localparam logic [3:0] OP_END = 4'd0;
  localparam logic [3:0] OP_U   = 4'd1;
`ifdef QEA_CTRL_GATE_EN
  localparam logic [3:0] OP_CU  = 4'd2;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_APPLY, S_DONE} state_e;

  state_e                        state_q;
  logic [MAX_QBIT_WIDTH-1:0]     n_q, tgt_q;
  logic [CAW-1:0]                pc_q;
  logic [2:0]                    fcnt_q;
  logic [GATE_DATA_WIDTH-1:0]    u_q [4];
  logic                          gate_ok_q;
  logic [PAIR_W-1:0]             pair_q;
  logic                          phase_q, wr_q;
  logic [STATE_ADDR_WIDTH-1:0]   wa0_q, wa1_q;
  logic [WORD_W-1:0]             wd0_q, wd1_q, dout_q;
  logic                          complete_q;
`ifdef QEA_CTRL_GATE_EN
  logic [MAX_QBIT_WIDTH-1:0]     ctrl_q;
  logic                          is_cu_q;
`endif

  logic [WORD_W-1:0] smem [SDEPTH];
  logic [CDW-1:0]    cmem [CDEPTH];

  // Signed complex multiply-accumulate: ua*aa + ub*ab, rescaled from Q4.60 to Q2.30.
  function automatic logic signed [MW-1:0] smul(input logic signed [ALU_DATA_WIDTH-1:0] x,
                                                input logic signed [ALU_DATA_WIDTH-1:0] y);
    smul = MW'(x) * MW'(y);
  endfunction

  function automatic logic [STATE_DATA_WIDTH-1:0] cmac(
    input logic [GATE_DATA_WIDTH-1:0] ua, input logic [STATE_DATA_WIDTH-1:0] aa,
    input logic [GATE_DATA_WIDTH-1:0] ub, input logic [STATE_DATA_WIDTH-1:0] ab);
    logic signed [DATA_WIDTH-1:0] uar, uai, aar, aai, ubr, ubi, abr, abi;
    logic signed [MW-1:0] sr, si;
    {uar, uai} = ua;
    {aar, aai} = aa;
    {ubr, ubi} = ub;
    {abr, abi} = ab;
    sr = smul(uar, aar) - smul(uai, aai) + smul(ubr, abr) - smul(ubi, abi);
    si = smul(uar, aai) + smul(uai, aar) + smul(ubr, abi) + smul(ubi, abr);
    cmac = {sr[NUM_FRAC_BIT +: DATA_WIDTH], si[NUM_FRAC_BIT +: DATA_WIDTH]};
  endfunction

  logic busy, apply_wr;
  assign busy     = (state_q == S_FETCH) || (state_q == S_APPLY);
  assign apply_wr = (state_q == S_APPLY) && phase_q && wr_q;

  // Program fetch and header decode
  logic [CAW-1:0]            ctx_addr;
  logic [CDW-1:0]            ctx_rd;
  logic [3:0]                hdr_op;
  logic [MAX_QBIT_WIDTH-1:0] hdr_tgt;
  logic                      hdr_end, hdr_ok;
`ifdef QEA_CTRL_GATE_EN
  logic [MAX_QBIT_WIDTH-1:0] hdr_ctrl;
  assign hdr_ctrl = ctx_rd[CDW-11 -: MAX_QBIT_WIDTH];
`endif

  assign ctx_addr = pc_q + CAW'(fcnt_q);
  assign ctx_rd   = cmem[ctx_addr];
  assign hdr_op   = ctx_rd[CDW-1 -: 4];
  assign hdr_tgt  = ctx_rd[CDW-5 -: MAX_QBIT_WIDTH];
  assign hdr_end  = (hdr_op == OP_END) || (pc_q >= PC_LIMIT);

  always_comb begin
    hdr_ok = 1'b0;
    if (hdr_op == OP_U) hdr_ok = (hdr_tgt < n_q);
`ifdef QEA_CTRL_GATE_EN
    if (hdr_op == OP_CU) hdr_ok = (hdr_tgt < n_q) && (hdr_ctrl < n_q) && (hdr_ctrl != hdr_tgt);
`endif
  end

  // Pair addressing: insert a 0 at the target bit of the pair index
  logic [AMP_W-1:0]            jx, low_mask, k0, k1;
  logic [STATE_ADDR_WIDTH-1:0] addr0, addr1;
  logic [PE_NUM_WIDTH-1:0]     lane0, lane1;
  logic [PAIR_W-1:0]           pair_last;
  logic                        ctrl_ok;

  assign jx        = AMP_W'(pair_q);
  assign low_mask  = (AMP_W'(1) << tgt_q) - AMP_W'(1);
  assign k0        = ((jx & ~low_mask) << 1) | (jx & low_mask);
  assign k1        = k0 | (AMP_W'(1) << tgt_q);
  assign addr0     = k0[AMP_W-1:PE_NUM_WIDTH];
  assign addr1     = k1[AMP_W-1:PE_NUM_WIDTH];
  assign lane0     = k0[PE_NUM_WIDTH-1:0];
  assign lane1     = k1[PE_NUM_WIDTH-1:0];
  assign pair_last = PAIR_W'((AMP_W'(1) << (n_q - MAX_QBIT_WIDTH'(1))) - AMP_W'(1));

`ifdef QEA_CTRL_GATE_EN
  assign ctrl_ok = !is_cu_q || (|((k0 >> ctrl_q) & AMP_W'(1)));
`else
  assign ctrl_ok = 1'b1;
`endif

  // Read both words, update the two lanes, produce new words
  logic [WORD_W-1:0]           w0, w1, nw0, nw1;
  logic [STATE_DATA_WIDTH-1:0] a0, a1, n0, n1;

  always_comb begin
    w0  = smem[addr0];
    w1  = smem[addr1];
    a0  = '0;
    a1  = '0;
    for (int unsigned l = 0; l < PE_NUM; l++) begin
      if (lane0 == PE_NUM_WIDTH'(l)) a0 = w0[(PE_NUM-1-l)*STATE_DATA_WIDTH +: STATE_DATA_WIDTH];
      if (lane1 == PE_NUM_WIDTH'(l)) a1 = w1[(PE_NUM-1-l)*STATE_DATA_WIDTH +: STATE_DATA_WIDTH];
    end
    n0  = cmac(u_q[0], a0, u_q[1], a1);
    n1  = cmac(u_q[2], a0, u_q[3], a1);
    nw0 = w0;
    nw1 = w1;
    for (int unsigned l = 0; l < PE_NUM; l++) begin
      if (lane0 == PE_NUM_WIDTH'(l)) nw0[(PE_NUM-1-l)*STATE_DATA_WIDTH +: STATE_DATA_WIDTH] = n0;
      if (lane1 == PE_NUM_WIDTH'(l)) nw1[(PE_NUM-1-l)*STATE_DATA_WIDTH +: STATE_DATA_WIDTH] = n1;
      if (addr0 == addr1 && lane1 == PE_NUM_WIDTH'(l))
        nw0[(PE_NUM-1-l)*STATE_DATA_WIDTH +: STATE_DATA_WIDTH] = n1;
    end
    if (addr0 == addr1) nw1 = nw0;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      tgt_q      <= '0;
      pc_q       <= '0;
      fcnt_q     <= '0;
      gate_ok_q  <= 1'b0;
      pair_q     <= '0;
      phase_q    <= 1'b0;
      wr_q       <= 1'b0;
      wa0_q      <= '0;
      wa1_q      <= '0;
      wd0_q      <= '0;
      wd1_q      <= '0;
      complete_q <= 1'b0;
      for (int i = 0; i < 4; i++) u_q[i] <= '0;
`ifdef QEA_CTRL_GATE_EN
      ctrl_q     <= '0;
      is_cu_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state_q    <= S_FETCH;
            n_q        <= i_qbit_num;
            pc_q       <= '0;
            fcnt_q     <= '0;
            complete_q <= 1'b0;
          end
        end
        S_FETCH: begin
          if (fcnt_q == 3'd0) begin
            if (hdr_end) begin
              state_q    <= S_DONE;
              complete_q <= 1'b1;
            end else begin
              tgt_q     <= hdr_tgt;
              gate_ok_q <= hdr_ok;
`ifdef QEA_CTRL_GATE_EN
              ctrl_q    <= hdr_ctrl;
              is_cu_q   <= (hdr_op == OP_CU);
`endif
              fcnt_q    <= 3'd1;
            end
          end else begin
            u_q[2'(fcnt_q - 3'd1)] <= ctx_rd;
            if (fcnt_q == 3'd4) begin
              fcnt_q <= '0;
              pc_q   <= pc_q + CAW'(5);
              if (gate_ok_q) begin
                state_q <= S_APPLY;
                pair_q  <= '0;
                phase_q <= 1'b0;
              end
            end else begin
              fcnt_q <= fcnt_q + 3'd1;
            end
          end
        end
        S_APPLY: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            wr_q    <= ctrl_ok;
            wa0_q   <= addr0;
            wa1_q   <= addr1;
            wd0_q   <= nw0;
            wd1_q   <= nw1;
          end else begin
            phase_q <= 1'b0;
            wr_q    <= 1'b0;
            if (pair_q == pair_last) state_q <= S_FETCH;
            else                     pair_q  <= pair_q + PAIR_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // State RAM: host port blocked while busy; engine write-back in APPLY
  always_ff @(posedge clk) begin
    if (i_state_ena && i_state_wea && !busy) smem[i_state_addra] <= i_state_dina;
    if (apply_wr) begin
      smem[wa0_q] <= wd0_q;
      smem[wa1_q] <= wd1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (i_ctx_en && i_ctx_wea && !busy) cmem[i_ctx_addr] <= i_ctx_data;
  end

  // Read-first host read register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           dout_q <= '0;
    else if (i_state_ena) dout_q <= smem[i_state_addra];
  end

  assign o_complete   = complete_q;
  assign o_state_dout = dout_q;

endmodule

// File: tb/tb_qea_engine.sv
// Self-checking bench for qea_engine: scoreboard of expected state words checked on readback.
module tb_qea_engine;
  localparam int unsigned WW  = 256;
  localparam int unsigned SAW = 16;
  localparam int unsigned CAW = 16;
  localparam int unsigned QW  = 6;
  localparam logic [63:0] ONE = 64'h40000000_00000000;
  localparam logic [63:0] H   = 64'h2D413CCC_00000000;
  localparam logic [63:0] HN  = 64'hD2BEC334_00000000;
  localparam logic [63:0] Z   = 64'h0;

  logic           clk, rst_n, i_start;
  logic [QW-1:0]  i_qbit_num;
  logic           i_ctx_en, i_ctx_wea;
  logic [CAW-1:0] i_ctx_addr;
  logic [63:0]    i_ctx_data;
  logic           i_state_ena, i_state_wea;
  logic [SAW-1:0] i_state_addra;
  logic [WW-1:0]  i_state_dina;
  logic           o_complete;
  logic [WW-1:0]  o_state_dout;

  int errors = 0;
  int checks = 0;
  logic [WW-1:0] exp_q[$];

  qea_engine dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_qbit_num(i_qbit_num),
    .i_ctx_en(i_ctx_en), .i_ctx_wea(i_ctx_wea), .i_ctx_addr(i_ctx_addr), .i_ctx_data(i_ctx_data),
    .i_state_ena(i_state_ena), .i_state_wea(i_state_wea), .i_state_addra(i_state_addra),
    .i_state_dina(i_state_dina), .o_complete(o_complete), .o_state_dout(o_state_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_state(input logic [SAW-1:0] a, input logic [WW-1:0] d);
    i_state_ena = 1'b1; i_state_wea = 1'b1; i_state_addra = a; i_state_dina = d;
    tick();
    i_state_ena = 1'b0; i_state_wea = 1'b0;
  endtask

  task automatic wr_ctx(input logic [CAW-1:0] a, input logic [63:0] d);
    i_ctx_en = 1'b1; i_ctx_wea = 1'b1; i_ctx_addr = a; i_ctx_data = d;
    tick();
    i_ctx_en = 1'b0; i_ctx_wea = 1'b0;
  endtask

  task automatic wr_gate(input logic [CAW-1:0] pc, input logic [3:0] op, input logic [5:0] t,
                         input logic [5:0] c, input logic [63:0] u00, input logic [63:0] u01,
                         input logic [63:0] u10, input logic [63:0] u11);
    wr_ctx(pc, {op, t, c, 48'h0});
    wr_ctx(pc + 16'd1, u00);
    wr_ctx(pc + 16'd2, u01);
    wr_ctx(pc + 16'd3, u10);
    wr_ctx(pc + 16'd4, u11);
  endtask

  task automatic read_word(input logic [SAW-1:0] a, output logic [WW-1:0] d);
    i_state_ena = 1'b1; i_state_wea = 1'b0; i_state_addra = a;
    tick();
    d = o_state_dout;
    i_state_ena = 1'b0;
  endtask

  task automatic start_prog(input logic [QW-1:0] n);
    i_qbit_num = n; i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit ok);
    cyc = 0;
    while (!o_complete && cyc < budget) begin
      tick();
      cyc++;
    end
    ok = o_complete;
  endtask

  function automatic logic [31:0] rnd();
    rnd = $urandom_range(0, 32'h3FFF_FFFF) - 32'h2000_0000;
  endfunction

  function automatic logic [63:0] ref_mac(input logic [63:0] u, input logic [63:0] a,
                                          input logic [63:0] v, input logic [63:0] b);
    longint ur, ui, ar, ai, vr, vi, br, bi, sr, si;
    ur = $signed(u[63:32]); ui = $signed(u[31:0]);
    ar = $signed(a[63:32]); ai = $signed(a[31:0]);
    vr = $signed(v[63:32]); vi = $signed(v[31:0]);
    br = $signed(b[63:32]); bi = $signed(b[31:0]);
    sr = ur * ar - ui * ai + vr * br - vi * bi;
    si = ur * ai + ui * ar + vr * bi + vi * br;
    sr = sr >>> 30;
    si = si >>> 30;
    return {sr[31:0], si[31:0]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (o_complete !== 1'b0) begin errors++; $display("FAIL reset_complete: got %b want 0", o_complete); end
    checks++;
    if (o_state_dout !== '0) begin errors++; $display("FAIL reset_dout: got %h want 0", o_state_dout); end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (o_complete !== 1'b0) begin errors++; $display("FAIL idle_complete: got %b want 0", o_complete); end
  endtask

  task automatic test_readback();
    logic [WW-1:0] p, q, r, got, exp;
    p = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    q = ~p;
    r = {p[127:0], q[255:128]};
    wr_state(16'd20, p);
    wr_state(16'd21, q);
    exp_q.push_back(p);
    read_word(16'd20, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rd_word: got %h want %h", got, exp); end
    exp_q.push_back(p);
    i_state_addra = 16'd21; i_state_ena = 1'b0;
    tick();
    exp = exp_q.pop_front(); checks++;
    if (o_state_dout !== exp) begin errors++; $display("FAIL rd_hold: got %h want %h", o_state_dout, exp); end
    exp_q.push_back(p);
    i_state_ena = 1'b1; i_state_wea = 1'b1; i_state_addra = 16'd20; i_state_dina = r;
    tick();
    i_state_ena = 1'b0; i_state_wea = 1'b0;
    exp = exp_q.pop_front(); checks++;
    if (o_state_dout !== exp) begin errors++; $display("FAIL rd_first: got %h want %h", o_state_dout, exp); end
    exp_q.push_back(r);
    read_word(16'd20, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rd_after_wr: got %h want %h", got, exp); end
  endtask

  task automatic test_hadamard();
    logic [WW-1:0] got, exp;
    int cyc; bit ok;
    wr_state(16'd0, {ONE, Z, Z, Z});
    wr_state(16'd1, '0);
    wr_gate(16'd0, 4'd1, 6'd0, 6'd0, H, H, H, HN);
    wr_ctx(16'd5, 64'h0);
    exp_q.push_back({H, H, Z, Z});
    exp_q.push_back('0);
    start_prog(6'd3);
    wait_done(200, cyc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL had_done: complete=%b want 1 after %0d cycles", o_complete, cyc); end
    for (int a = 0; a < 2; a++) begin
      read_word(SAW'(a), got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL had_word%0d: got %h want %h", a, got, exp); end
    end
  endtask

  task automatic test_pauli_x();
    logic [WW-1:0] got, exp;
    int cyc; bit ok;
    wr_state(16'd0, {ONE, Z, Z, Z});
    wr_state(16'd1, '0);
    wr_gate(16'd0, 4'd1, 6'd2, 6'd0, Z, ONE, ONE, Z);
    wr_ctx(16'd5, 64'h0);
    exp_q.push_back('0);
    exp_q.push_back({ONE, Z, Z, Z});
    start_prog(6'd3);
    wait_done(200, cyc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL x_done: complete=%b want 1 after %0d cycles", o_complete, cyc); end
    for (int a = 0; a < 2; a++) begin
      read_word(SAW'(a), got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL x_word%0d: got %h want %h", a, got, exp); end
    end
  endtask

  task automatic test_end_only();
    logic [WW-1:0] got, exp, w0, w1;
    int cyc; bit ok;
    w0 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    w1 = {w0[31:0], w0[255:32]};
    wr_state(16'd0, w0);
    wr_state(16'd1, w1);
    wr_ctx(16'd0, 64'h0);
    exp_q.push_back(w0);
    exp_q.push_back(w1);
    start_prog(6'd3);
    checks++;
    if (o_complete !== 1'b0) begin errors++; $display("FAIL end_clear: got %b want 0", o_complete); end
    wait_done(10, cyc, ok);
    checks++;
    if (!ok || cyc + 1 > 3) begin
      errors++; $display("FAIL end_latency: complete=%b cycles=%0d want 1 within 3", o_complete, cyc + 1);
    end
    for (int a = 0; a < 2; a++) begin
      read_word(SAW'(a), got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL end_word%0d: got %h want %h", a, got, exp); end
    end
  endtask

  task automatic test_noop();
    logic [WW-1:0] got, exp, w0, w1;
    int cyc; bit ok;
    w0 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    w1 = ~w0;
    wr_state(16'd0, w0);
    wr_state(16'd1, w1);
    wr_gate(16'd0,  4'd1, 6'd3, 6'd0, Z, ONE, ONE, Z);
    wr_gate(16'd5,  4'd2, 6'd1, 6'd1, Z, ONE, ONE, Z);
    wr_gate(16'd10, 4'd7, 6'd0, 6'd1, Z, ONE, ONE, Z);
    wr_ctx(16'd15, 64'h0);
    exp_q.push_back(w0);
    exp_q.push_back(w1);
    start_prog(6'd3);
    wait_done(100, cyc, ok);
    checks++;
    if (!ok || cyc != 16) begin
      errors++; $display("FAIL noop_cycles: complete=%b cycles=%0d want 1 at 16", o_complete, cyc);
    end
    for (int a = 0; a < 2; a++) begin
      read_word(SAW'(a), got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL noop_word%0d: got %h want %h", a, got, exp); end
    end
  endtask

  task automatic test_ctrl_gate();
    logic [WW-1:0] got, exp;
    int cyc; bit ok;
    wr_state(16'd0, {ONE, Z, Z, Z});
    wr_state(16'd1, '0);
    wr_gate(16'd0, 4'd1, 6'd0, 6'd0, H, H, H, HN);
    wr_gate(16'd5, 4'd2, 6'd1, 6'd0, Z, ONE, ONE, Z);
    wr_ctx(16'd10, 64'h0);
`ifdef QEA_CTRL_GATE_EN
    exp_q.push_back({H, Z, Z, H});
`else
    exp_q.push_back({H, H, Z, Z});
`endif
    exp_q.push_back('0);
    start_prog(6'd3);
    wait_done(200, cyc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cu_done: complete=%b want 1 after %0d cycles", o_complete, cyc); end
    for (int a = 0; a < 2; a++) begin
      read_word(SAW'(a), got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL cu_word%0d: got %h want %h", a, got, exp); end
    end
  endtask

  task automatic test_random_gate();
    logic [63:0] m [16];
    logic [63:0] u [4];
    logic [63:0] a, b;
    logic [WW-1:0] got, exp;
    int cyc; bit ok;
    int k1;
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 16; k++) m[k] = {rnd(), rnd()};
      for (int i = 0; i < 4; i++) u[i] = {rnd(), rnd()};
      for (int w = 0; w < 4; w++) wr_state(SAW'(w), {m[4*w], m[4*w+1], m[4*w+2], m[4*w+3]});
      wr_gate(16'd0, 4'd1, 6'(t), 6'd0, u[0], u[1], u[2], u[3]);
      wr_ctx(16'd5, 64'h0);
      for (int k = 0; k < 16; k++) begin
        if (((k >> t) & 1) == 0) begin
          k1 = k | (1 << t);
          a = m[k]; b = m[k1];
          m[k]  = ref_mac(u[0], a, u[1], b);
          m[k1] = ref_mac(u[2], a, u[3], b);
        end
      end
      for (int w = 0; w < 4; w++) exp_q.push_back({m[4*w], m[4*w+1], m[4*w+2], m[4*w+3]});
      start_prog(6'd4);
      wait_done(200, cyc, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rnd_done_t%0d: complete=%b want 1", t, o_complete); end
      for (int w = 0; w < 4; w++) begin
        read_word(SAW'(w), got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rnd_t%0d_word%0d: got %h want %h", t, w, got, exp); end
      end
    end
  endtask

  task automatic test_busy_write();
    logic [WW-1:0] got, exp, p;
    int cyc; bit ok;
    p = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    wr_state(16'd0, {ONE, Z, Z, Z});
    wr_state(16'd1, '0);
    wr_state(16'd7, p);
    wr_gate(16'd0, 4'd1, 6'd2, 6'd0, Z, ONE, ONE, Z);
    wr_ctx(16'd5, 64'h0);
    exp_q.push_back('0);
    exp_q.push_back({ONE, Z, Z, Z});
    exp_q.push_back(p);
    start_prog(6'd3);
    wr_state(16'd7, ~p);
    wait_done(200, cyc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_done: complete=%b want 1", o_complete); end
    for (int a = 0; a < 3; a++) begin
      read_word((a == 2) ? 16'd7 : SAW'(a), got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL busy_word%0d: got %h want %h", a, got, exp); end
    end
  endtask

  task automatic test_reset_mid_apply();
    logic [WW-1:0] got, exp;
    int cyc; bit ok;
    wr_state(16'd0, {ONE, Z, Z, Z});
    wr_state(16'd1, '0);
    wr_gate(16'd0, 4'd1, 6'd2, 6'd0, Z, ONE, ONE, Z);
    wr_ctx(16'd5, 64'h0);
    exp_q.push_back({ONE, Z, Z, Z});
    read_word(16'd0, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rst_pre_word: got %h want %h", got, exp); end
    start_prog(6'd3);
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_complete !== 1'b0) begin errors++; $display("FAIL rst_mid_complete: got %b want 0", o_complete); end
    checks++;
    if (o_state_dout !== '0) begin errors++; $display("FAIL rst_mid_dout: got %h want 0", o_state_dout); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (o_complete !== 1'b0) begin errors++; $display("FAIL rst_idle: got %b want 0", o_complete); end
    wr_state(16'd0, {ONE, Z, Z, Z});
    wr_state(16'd1, '0);
    wr_gate(16'd0, 4'd1, 6'd2, 6'd0, Z, ONE, ONE, Z);
    wr_ctx(16'd5, 64'h0);
    exp_q.push_back('0);
    exp_q.push_back({ONE, Z, Z, Z});
    start_prog(6'd3);
    wait_done(200, cyc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_rerun_done: complete=%b want 1", o_complete); end
    for (int a = 0; a < 2; a++) begin
      read_word(SAW'(a), got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL rst_rerun_word%0d: got %h want %h", a, got, exp); end
    end
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_qbit_num = '0;
    i_ctx_en = 1'b0; i_ctx_wea = 1'b0; i_ctx_addr = '0; i_ctx_data = '0;
    i_state_ena = 1'b0; i_state_wea = 1'b0; i_state_addra = '0; i_state_dina = '0;
    test_reset();
    test_readback();
    test_hadamard();
    test_pauli_x();
    test_end_only();
    test_noop();
    test_ctrl_gate();
    test_random_gate();
    test_busy_write();
    test_reset_mid_apply();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
